regs_access_ctrl: RTL and testbench

- Requester-side controller for the `regs` register file. It sequences operand reads and writeback writes into that file.
- Sits between decode, execute and writeback. Accepts decoded source/destination addresses over a valid/ready handshake and drives the file's active-low `rs_read` / `rd_write_in` strobes.
- Captures the file's one-edge-latency read data and presents a coherent operand pair downstream. Writebacks committed on the read edge are honoured.

---
 rtl/regs_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_regs_access_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regs_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regs_access_ctrl
// Brief    : Requester-side sequencer for the regs file: operand reads + writeback.
//            Optional ISSUE-cycle writeback bypass enabled by macro REGS_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regs_access_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            req,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic [AW-1:0]   dec_rd,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_rs1_value,
  output logic [XLEN-1:0] op_rs2_value,
  output logic [AW-1:0]   op_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_value,
  output logic            rf_rs_read,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [AW-1:0]   rf_rd,
  output logic            rf_rd_write,
  output logic [XLEN-1:0] rf_rd_value,
  input  logic [XLEN-1:0] rf_rs1_value,
  input  logic [XLEN-1:0] rf_rs2_value
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [AW-1:0]   r_rd;
  logic            w_wb_live;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_hazard;
  logic            w_accept;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;

  // A write landing on the ISSUE edge is invisible to that read.
  assign w_wb_live = wb_valid & (wb_rd != '0);
  assign w_hit1    = w_wb_live & (wb_rd == r_rs1);
  assign w_hit2    = w_wb_live & (wb_rd == r_rs2);
  assign w_hazard  = w_hit1 | w_hit2;
  assign w_accept  = dec_valid & dec_ready;

  assign rf_rs1      = r_rs1;
  assign rf_rs2      = r_rs2;
  assign rf_rd       = wb_rd;
  assign rf_rd_value = wb_value;
  assign rf_rd_write = ~(w_wb_live & ~rst);

  always_comb begin
    w_state_nxt = r_state;
    dec_ready   = 1'b0;
    op_valid    = 1'b0;
    rf_rs_read  = 1'b1;
    case (r_state)
      S_IDLE: begin
        dec_ready = ~rst;
        if (dec_valid & ~rst) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        rf_rs_read = 1'b0;
`ifdef REGS_BYPASS_EN
        w_state_nxt = S_CAPTURE;
`else
        if (!w_hazard) w_state_nxt = S_CAPTURE;
`endif
      end
      S_CAPTURE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef REGS_BYPASS_EN
  logic            r_byp1_vld;
  logic            r_byp2_vld;
  logic [XLEN-1:0] r_byp1;
  logic [XLEN-1:0] r_byp2;

  always_ff @(posedge req or posedge rst) begin
    if (rst) begin
      r_byp1_vld <= 1'b0;
      r_byp2_vld <= 1'b0;
      r_byp1     <= '0;
      r_byp2     <= '0;
    end else if (w_accept) begin
      r_byp1_vld <= 1'b0;
      r_byp2_vld <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      if (w_hit1) begin
        r_byp1     <= wb_value;
        r_byp1_vld <= 1'b1;
      end
      if (w_hit2) begin
        r_byp2     <= wb_value;
        r_byp2_vld <= 1'b1;
      end
    end
  end

  assign w_src1 = r_byp1_vld ? r_byp1 : rf_rs1_value;
  assign w_src2 = r_byp2_vld ? r_byp2 : rf_rs2_value;
`else
  assign w_src1 = rf_rs1_value;
  assign w_src2 = rf_rs2_value;
`endif

  always_ff @(posedge req or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      op_rs1_value <= '0;
      op_rs2_value <= '0;
      op_rd        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rs1 <= dec_rs1;
        r_rs2 <= dec_rs2;
        r_rd  <= dec_rd;
      end
      // x0 reads as zero regardless of what the file returns
      if (r_state == S_CAPTURE) begin
        op_rs1_value <= (r_rs1 == '0) ? '0 : w_src1;
        op_rs2_value <= (r_rs2 == '0) ? '0 : w_src2;
        op_rd        <= r_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regs_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regs_access_ctrl
// Brief    : Self-checking bench for regs_access_ctrl with a register file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regs_access_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            req = 1'b0;
  logic            rst;
  logic            dec_valid;
  logic            dec_ready;
  logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_rs1_value, op_rs2_value;
  logic [AW-1:0]   op_rd;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_value;
  logic            rf_rs_read;
  logic [AW-1:0]   rf_rs1, rf_rs2, rf_rd;
  logic            rf_rd_write;
  logic [XLEN-1:0] rf_rd_value;
  logic [XLEN-1:0] rf_rs1_value = '0;
  logic [XLEN-1:0] rf_rs2_value = '0;

  always #5 req = ~req;

  regs_access_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .req(req), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_value(op_rs1_value), .op_rs2_value(op_rs2_value), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
    .rf_rs_read(rf_rs_read), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_rd_write(rf_rd_write), .rf_rd_value(rf_rd_value),
    .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value)
  );

  // External register file: read returns pre-edge contents, one-edge latency.
  logic [XLEN-1:0] mem [32] = '{default: 32'hDEAD_0000};
  always @(posedge req) begin
    if (!rf_rs_read) begin
      rf_rs1_value <= mem[rf_rs1];
      rf_rs2_value <= mem[rf_rs2];
    end
    if (!rf_rd_write) mem[rf_rd] <= rf_rd_value;
  end

  // Architectural reference: contents after every committed writeback.
  logic [XLEN-1:0] arch [32] = '{default: 32'hDEAD_0000};
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge req);
    if (wb_valid && wb_rd != '0 && !rst) arch[wb_rd] = wb_value;
    #1;
  endtask

  task automatic set_wb(input bit v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    wb_valid = v; wb_rd = r; wb_value = d;
  endtask

  task automatic rnd_wb();
    set_wb(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic check_wb();
    check("rd_write", {31'b0, rf_rd_write}, {31'b0, !(wb_valid && wb_rd != '0 && !rst)});
  endtask

  task automatic wb_cycle(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    set_wb(1'b1, r, d);
    #1; check_wb();
    step();
    set_wb(1'b0, '0, '0);
  endtask

  function automatic logic [XLEN-1:0] expv(input logic [AW-1:0] a);
    return (a == '0) ? '0 : arch[a];
  endfunction

  task automatic txn(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] d,
                     input int hold, input bit rnd,
                     input bit iss_en, input logic [AW-1:0] iss_rd, input logic [XLEN-1:0] iss_val,
                     input bit cap_en, input logic [AW-1:0] cap_rd, input logic [XLEN-1:0] cap_val);
    logic [XLEN-1:0] e1, e2;
    bit haz;
    int stalls;
    dec_valid = 1'b1; dec_rs1 = a1; dec_rs2 = a2; dec_rd = d;
    if (rnd) rnd_wb(); else set_wb(1'b0, '0, '0);
    #1; check("dec_ready_idle", {31'b0, dec_ready}, 1); check_wb();
    step();
    dec_valid = 1'b0; dec_rs1 = AW'($urandom); dec_rs2 = AW'($urandom); dec_rd = AW'($urandom);
    // Issue phase: a hazard either bypasses or costs one more issue cycle.
    stalls = 0;
    forever begin
      if (stalls == 0 && iss_en) set_wb(1'b1, iss_rd, iss_val);
      else if (rnd) rnd_wb();
      else set_wb(1'b0, '0, '0);
      haz = wb_valid && wb_rd != '0 && (wb_rd == a1 || wb_rd == a2);
      #1;
      check("rs_read_issue", {31'b0, rf_rs_read}, 0);
      check("dec_ready_busy", {31'b0, dec_ready}, 0);
      check("op_valid_issue", {31'b0, op_valid}, 0);
      step();
      if (!haz || BYP || stalls >= 40) break;
      stalls++;
    end
    e1 = expv(a1);
    e2 = expv(a2);
    if (cap_en) set_wb(1'b1, cap_rd, cap_val); else if (rnd) rnd_wb(); else set_wb(1'b0, '0, '0);
    #1;
    check("rs_read_capture", {31'b0, rf_rs_read}, 1);
    check("op_valid_capture", {31'b0, op_valid}, 0);
    check_wb();
    step();
    for (int i = 0; i <= hold; i++) begin
      op_ready = (i == hold);
      if (rnd) rnd_wb(); else set_wb(1'b0, '0, '0);
      #1;
      check("op_valid_hold", {31'b0, op_valid}, 1);
      check("op_rs1", op_rs1_value, e1);
      check("op_rs2", op_rs2_value, e2);
      check("op_rd", {27'b0, op_rd}, {27'b0, d});
      check("dec_ready_hold", {31'b0, dec_ready}, 0);
      step();
    end
    op_ready = 1'b0;
    set_wb(1'b0, '0, '0);
    #1;
    check("op_valid_done", {31'b0, op_valid}, 0);
    check("dec_ready_done", {31'b0, dec_ready}, 1);
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; op_ready = 1'b0;
    set_wb(1'b1, 5'd5, 32'h9999);
    step(); step();
    check("rst_dec_ready", {31'b0, dec_ready}, 0);
    check("rst_op_valid", {31'b0, op_valid}, 0);
    check("rst_op_rs1", op_rs1_value, 0);
    check("rst_op_rs2", op_rs2_value, 0);
    check("rst_op_rd", {27'b0, op_rd}, 0);
    check("rst_rs_read", {31'b0, rf_rs_read}, 1);
    check_wb();
    rst = 1'b0;
    set_wb(1'b0, '0, '0);
    #1; check("post_rst_ready", {31'b0, dec_ready}, 1);

    for (int r = 1; r < 32; r++) wb_cycle(AW'(r), $urandom);
    wb_cycle(5'd5, 32'h1234);
    wb_cycle(5'd6, 32'hBEEF);
    txn(5'd5, 5'd6, 5'd7, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    wb_cycle(5'd0, 32'hFFFF_FFFF);
    txn(5'd0, 5'd0, 5'd3, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    txn(5'd5, 5'd6, 5'd1, 0, 1'b0, 1'b1, 5'd5, 32'hAAAA, 1'b0, '0, '0);
    txn(5'd5, 5'd6, 5'd2, 0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h5555);
    txn(5'd6, 5'd5, 5'd8, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    txn(5'd1, 5'd2, 5'd9, 5, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    // Reset asserted while the read is being issued.
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd6; dec_rd = 5'd4;
    step();
    dec_valid = 1'b0;
    set_wb(1'b1, 5'd9, 32'h7777);
    rst = 1'b1;
    #1;
    check("mid_rst_op_valid", {31'b0, op_valid}, 0);
    check("mid_rst_rs_read", {31'b0, rf_rs_read}, 1);
    check("mid_rst_dec_ready", {31'b0, dec_ready}, 0);
    check_wb();
    step(); step();
    check("mid_rst_op_rs1", op_rs1_value, 0);
    check("mid_rst_op_rd", {27'b0, op_rd}, 0);
    check("mid_rst_dec_ready2", {31'b0, dec_ready}, 0);
    rst = 1'b0;
    set_wb(1'b0, '0, '0);
    #1;
    check("rel_dec_ready", {31'b0, dec_ready}, 1);
    check("rel_op_valid", {31'b0, op_valid}, 0);
    txn(5'd5, 5'd6, 5'd4, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    for (int n = 0; n < 60; n++)
      txn(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom),
          int'($urandom_range(0, 3)), 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
